pause_dim_ctl: RTL
==================

# pause_dim_ctl

Parametrised pause and screen-dim controller for arcade cores. It merges the user pause toggle with any number of external pause requests (hiscore RAM access, OSD open) into a single registered pause for the game core. While the user pause is held, a configurable timeout starts a frame-synchronous stepped fade of the RGB stream. It sits between the core's video output and the `arcade_video` block and supports configurable per-channel colour widths.

## Interface
- `N_SRC`, 2: number of external pause request inputs.
- `R_W`, 3: red channel width.
- `G_W`, 3: green channel width.
- `B_W`, 2: blue channel width.
- `DIM_TIMEOUT`, 480000000: `clk_sys` cycles of user pause before the fade starts (10 s at 48 MHz).
- `DIM_MAX`, 1: final right-shift applied to every channel, range 1..7.
- `FADE_FRAMES`, 8: vblank rising edges per fade step.

Ports:
- `clk_sys`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `user_pause`, in, 1: pause button level. Toggles on its rising edge.
- `toggle_clr`, in, 1: synchronous clear of the user toggle, e.g. on core reset.
- `pause_req`, in, N_SRC: external pause requests, level-sensitive.
- `rgb_in`, in, R_W+G_W+B_W: packed {r,g,b}.
- `hblank_in`, in, 1: horizontal blank to be delayed with the video.
- `vblank_in`, in, 1: vertical blank to be delayed with the video.
- `rgb_out`, out, R_W+G_W+B_W: dimmed, packed {r,g,b}.
- `hblank_out`, out, 1: delayed horizontal blank.
- `vblank_out`, out, 1: delayed vertical blank.
- `pause`, out, 1: `user_toggle | (|pause_req)`, registered.
- `user_paused`, out, 1: current user toggle state.
- `dim_level`, out, 3: current shift, 0..DIM_MAX.

## Operation
- Edge detect: `old_btn` is registered from `user_pause`. A rising edge is `user_pause & ~old_btn`, and it inverts `user_toggle`.
- `toggle_clr` has priority over a coincident edge and forces `user_toggle`=0.
- Timer: 32-bit.
  - Increments while `user_toggle`=1 and the timer is below DIM_TIMEOUT.
  - Saturates at DIM_TIMEOUT.
  - Cleared to 0 on any cycle where `user_toggle`=0.
- External `pause_req` never starts the timer or the fade.
- FSM states:
  - RUN: `dim_level`=0.
    - Go to WAIT when `user_toggle`=1.
  - WAIT: timer counting.
    - Go to FADE when timer==DIM_TIMEOUT. On entry, the frame counter is cleared.
    - Go to RUN when `user_toggle`=0.
  - FADE: count vblank rising edges (`vblank_in & ~vblank_d`).
    - After FADE_FRAMES edges, increment `dim_level` and clear the frame counter.
    - Go to DIMMED when `dim_level` reaches DIM_MAX.
  - DIMMED: hold `dim_level`=DIM_MAX.
- From FADE or DIMMED, `user_toggle`=0 gives next state RUN with `dim_level`=0 in the same update. There is no fade-in.
- Dim arithmetic:
  - Each channel is logically right-shifted by `dim_level` within its own width.
  - Shifts ≥ the channel width yield 0.
  - Channels are never mixed across packing boundaries.

## Timing
- Reset (`reset_n`=0, asynchronous), all outputs 0:
  - `rgb_out`, `hblank_out`, `vblank_out`, `pause`, `user_paused`, `dim_level` = 0.
  - FSM = RUN, timer = 0, `old_btn` = 0, `user_toggle` = 0.
- Reset asserted mid-fade drops straight to the reset state. There is no glitch beyond async clear.
- Video path:
  - Exactly 1 `clk_sys` of latency.
  - `rgb_out`, `hblank_out` and `vblank_out` are registered together every cycle, with no `ce_pix` gating. Pixel alignment with the blanks is preserved.
  - `dim_level` used for a pixel is the value registered before that edge.
- `pause`:
  - Asserts 1 cycle after a `pause_req` bit rises.
  - Asserts 2 cycles after a `user_pause` rising edge (edge detect, then toggle, then pause).
  - Deasserts with the same respective latencies.
- Timer: the first increment occurs on the cycle after `user_toggle` sets. FADE is entered DIM_TIMEOUT+1 cycles after `user_toggle` rises.
- Fade:
  - A vblank edge in the same cycle as the FADE entry is not counted.
  - A vblank edge coincident with toggle clear is ignored; RUN wins.
- A `user_pause` held high toggles once only.

## Test plan
- Reset: hold `reset_n`=0 with random inputs, release → all outputs 0 and `rgb_out` tracks `rgb_in` with 1-cycle lag, unshifted.
- Pause latencies and clear priority:
  - Pulse `pause_req[1]` → `pause` high after 1 cycle, low 1 cycle after the request drops.
  - `user_pause` rising edge → `pause` and `user_paused` high after 2 cycles.
  - A coincident `user_pause` edge plus `toggle_clr` → toggle stays 0.
- Fade, with DIM_TIMEOUT=100, FADE_FRAMES=2, DIM_MAX=2, 3/3/2 widths and `rgb_in`=8'hFF:
  - After toggle, `dim_level` stays 0 for 101 cycles.
  - After 2 vblank edges, `dim_level`=1 and `rgb_out`=8'b011_011_01.
  - After 2 more, `dim_level`=2 and `rgb_out`=8'b001_001_00, then holds.
- Unpause in DIMMED: press `user_pause` again → `dim_level`=0 and timer=0 in the same update, and `rgb_out`=8'hFF one cycle later.
- External request only: hold `pause_req[0]` for 200 cycles with DIM_TIMEOUT=100 → `pause`=1, `dim_level` remains 0 throughout.
- Reset mid-fade: assert `reset_n` low at `dim_level`=1 → all outputs 0 immediately (asynchronous). After release the FSM is in RUN and `user_paused`=0.

Source files
------------

// File: rtl/pause_dim_ctl.sv
// pause_dim_ctl
//   Merges the user pause toggle with external pause requests into one
//   registered pause for the game core. After the user pause has been held
//   for DIM_TIMEOUT cycles, the RGB stream is faded in frame-synchronous
//   steps (one right-shift per FADE_FRAMES vblank rising edges) up to
//   DIM_MAX. Unpausing restores full brightness immediately.
// Ports:
//   clk_sys, reset_n (async, active-low)
//   user_pause  : button level, toggles on rising edge
//   toggle_clr  : synchronous clear of the user toggle (wins over an edge)
//   pause_req   : external level-sensitive pause requests
//   rgb_in, hblank_in, vblank_in   : video in, packed {r,g,b}
//   rgb_out, hblank_out, vblank_out: video out, 1 cycle latency, dimmed
//   pause       : registered user_toggle | (|pause_req)
//   user_paused : current user toggle
//   dim_level   : current shift applied to every channel
module pause_dim_ctl #(
  parameter int unsigned N_SRC       = 2,
  parameter int unsigned R_W         = 3,
  parameter int unsigned G_W         = 3,
  parameter int unsigned B_W         = 2,
  parameter int unsigned DIM_TIMEOUT = 480000000,
  parameter int unsigned DIM_MAX     = 1,
  parameter int unsigned FADE_FRAMES = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     user_pause,
  input  logic                     toggle_clr,
  input  logic [N_SRC-1:0]         pause_req,
  input  logic [R_W+G_W+B_W-1:0]   rgb_in,
  input  logic                     hblank_in,
  input  logic                     vblank_in,
  output logic [R_W+G_W+B_W-1:0]   rgb_out,
  output logic                     hblank_out,
  output logic                     vblank_out,
  output logic                     pause,
  output logic                     user_paused,
  output logic [2:0]               dim_level
);

  localparam int unsigned W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_FADE,
    S_DIMMED
  } state_t;

  state_t      state_q, state_d;
  logic        old_btn_q;
  logic        user_toggle_q, user_toggle_d;
  logic        vblank_d_q;
  logic        pause_q, pause_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]  dim_level_q, dim_level_d;
  logic [W-1:0] rgb_q, rgb_d;
  logic        hblank_q, vblank_q;

  logic        btn_rise;
  logic        vb_rise;
  logic [R_W-1:0] r_dim;
  logic [G_W-1:0] g_dim;
  logic [B_W-1:0] b_dim;

  assign btn_rise = user_pause & ~old_btn_q;
  assign vb_rise  = vblank_in & ~vblank_d_q;

  // Toggle, merged pause and timeout timer
  always_comb begin
    user_toggle_d = user_toggle_q;
    if (toggle_clr)
      user_toggle_d = 1'b0;
    else if (btn_rise)
      user_toggle_d = ~user_toggle_q;

    pause_d = user_toggle_q | (|pause_req);

    timer_d = timer_q;
    if (!user_toggle_q)
      timer_d = '0;
    else if (timer_q < DIM_TIMEOUT)
      timer_d = timer_q + 32'd1;
  end

  // Fade FSM
  always_comb begin
    state_d     = state_q;
    dim_level_d = dim_level_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_RUN: begin
        dim_level_d = '0;
        if (user_toggle_q)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!user_toggle_q) begin
          state_d = S_RUN;
        end else if (timer_q == DIM_TIMEOUT) begin
          state_d     = S_FADE;
          frame_cnt_d = '0;
        end
      end
      S_FADE: begin
        if (!user_toggle_q) begin
          state_d     = S_RUN;
          dim_level_d = '0;
        end else if (vb_rise) begin
          if (frame_cnt_q + 32'd1 == FADE_FRAMES) begin
            frame_cnt_d = '0;
            dim_level_d = dim_level_q + 3'd1;
            if (dim_level_q + 3'd1 == 3'(DIM_MAX))
              state_d = S_DIMMED;
          end else begin
            frame_cnt_d = frame_cnt_q + 32'd1;
          end
        end
      end
      S_DIMMED: begin
        if (!user_toggle_q) begin
          state_d     = S_RUN;
          dim_level_d = '0;
        end else begin
          dim_level_d = 3'(DIM_MAX);
        end
      end
      default: begin
        state_d     = S_RUN;
        dim_level_d = '0;
      end
    endcase
  end

  // Per-channel shift; each channel is sliced out first so bits never
  // cross packing boundaries, and shifts beyond a channel width give 0.
  always_comb begin
    r_dim = rgb_in[W-1 -: R_W] >> dim_level_q;
    g_dim = rgb_in[G_W+B_W-1 -: G_W] >> dim_level_q;
    b_dim = rgb_in[B_W-1:0] >> dim_level_q;
    rgb_d = {r_dim, g_dim, b_dim};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      old_btn_q     <= 1'b0;
      user_toggle_q <= 1'b0;
      vblank_d_q    <= 1'b0;
      pause_q       <= 1'b0;
      timer_q       <= '0;
      frame_cnt_q   <= '0;
      dim_level_q   <= '0;
      rgb_q         <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      old_btn_q     <= user_pause;
      user_toggle_q <= user_toggle_d;
      vblank_d_q    <= vblank_in;
      pause_q       <= pause_d;
      timer_q       <= timer_d;
      frame_cnt_q   <= frame_cnt_d;
      dim_level_q   <= dim_level_d;
      rgb_q         <= rgb_d;
      hblank_q      <= hblank_in;
      vblank_q      <= vblank_in;
    end
  end

  assign rgb_out     = rgb_q;
  assign hblank_out  = hblank_q;
  assign vblank_out  = vblank_q;
  assign pause       = pause_q;
  assign user_paused = user_toggle_q;
  assign dim_level   = dim_level_q;

endmodule
